// File: rtl/mcc_defs.sv
// Shared definitions for the program_out capture path: default bus geometry
// and the two-state streamer FSM encoding.
package mcc_defs;

  localparam int DATA_BUS_WIDTH = 32;
  localparam int BYTE_WIDTH     = 8;
  localparam int BEATS_PER_WORD = DATA_BUS_WIDTH / BYTE_WIDTH;
  localparam int FIFO_DEPTH     = 4;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_t;

endpackage

// File: rtl/pout_fifo.sv
// Synchronous first-word-fall-through FIFO: dout always shows the head word
// while empty is low. Pointers carry one extra wrap bit to tell full from empty.
module pout_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]   rd_ptr_q, rd_ptr_d;
  logic             push_ok;
  logic             pop_ok;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                 (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
  assign level = wr_ptr_q - rd_ptr_q;
  assign dout  = mem[rd_ptr_q[PTR_W-1:0]];

  // NOTE: every signal written here gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    push_ok  = push && !full;
    pop_ok   = pop && !empty;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
  end

  // NOTE: state updates use <= so every flop samples pre-edge values, independent of statement order.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // NOTE: storage is deliberately not reset; the pointers alone decide what is valid.
  always_ff @(posedge clock) begin
    if (push_ok) mem[wr_ptr_q[PTR_W-1:0]] <= din;
  end

endmodule

// File: rtl/program_out_streamer.sv
// Watches program_out, queues each new value and streams it MSB byte first
// over a valid/ready handshake, flagging words dropped on a full queue.
module program_out_streamer #(
  parameter int DATA_BUS_WIDTH = mcc_defs::DATA_BUS_WIDTH,
  parameter int BYTE_WIDTH     = mcc_defs::BYTE_WIDTH,
  parameter int FIFO_DEPTH     = mcc_defs::FIFO_DEPTH
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [DATA_BUS_WIDTH-1:0]     program_out,
  input  logic                          capture_en,
  output logic [BYTE_WIDTH-1:0]         out_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic                          out_first,
  output logic                          overflow,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  import mcc_defs::*;

  localparam int BEATS = DATA_BUS_WIDTH / BYTE_WIDTH;
  localparam int BCW   = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [BCW-1:0] LAST_BEAT = BCW'(BEATS - 1);

  state_t                    state_q, state_d;
  logic [DATA_BUS_WIDTH-1:0] shift_q, shift_d;
  logic [BCW-1:0]            beat_cnt_q, beat_cnt_d;
  logic [DATA_BUS_WIDTH-1:0] last_val_q, last_val_d;
  logic                      primed_q, primed_d;
  logic                      overflow_q, overflow_d;

  logic                      push_req;
  logic                      fifo_push;
  logic                      fifo_pop;
  logic [DATA_BUS_WIDTH-1:0] fifo_dout;
  logic                      fifo_full;
  logic                      fifo_empty;

  pout_fifo #(
    .WIDTH (DATA_BUS_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (program_out),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  assign overflow = overflow_q;

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    beat_cnt_d = beat_cnt_q;
    last_val_d = last_val_q;
    primed_d   = primed_q;
    overflow_d = overflow_q;
    fifo_pop   = 1'b0;
    out_valid  = 1'b0;
    out_first  = 1'b0;
    out_data   = '0;

    // Fullness is judged before any same-cycle pop, so a full queue rejects the word.
    push_req  = capture_en && (!primed_q || (program_out != last_val_q));
    fifo_push = push_req && !fifo_full;
    if (push_req) begin
      last_val_d = program_out;
      primed_d   = 1'b1;
      if (fifo_full) overflow_d = 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop   = 1'b1;
          shift_d    = fifo_dout;
          beat_cnt_d = '0;
          state_d    = ST_SEND;
        end
      end
      ST_SEND: begin
        out_valid = 1'b1;
        out_data  = shift_q[DATA_BUS_WIDTH-1 -: BYTE_WIDTH];
        out_first = (beat_cnt_q == '0);
        if (out_ready) begin
          shift_d    = shift_q << BYTE_WIDTH;
          beat_cnt_d = beat_cnt_q + BCW'(1);
          if (beat_cnt_q == LAST_BEAT) state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      shift_q    <= '0;
      beat_cnt_q <= '0;
      last_val_q <= '0;
      primed_q   <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      beat_cnt_q <= beat_cnt_d;
      last_val_q <= last_val_d;
      primed_q   <= primed_d;
      overflow_q <= overflow_d;
    end
  end

endmodule

// File: tb/tb_program_out_streamer.sv
// Self-checking bench for program_out_streamer: byte scoreboard fed by the
// stimulus, a vector table for change detection, and hand-written corner cases.
module tb_program_out_streamer;

  logic        clock;
  logic        reset;
  logic [31:0] program_out;
  logic        capture_en;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready;
  logic        out_first;
  logic        overflow;
  logic [2:0]  fifo_level;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [7:0] data;
    logic       first;
  } beat_t;

  typedef struct {
    logic        cap;
    logic [31:0] val;
    logic        exp_push;
  } vec_t;

  beat_t exp_q[$];
  vec_t  vecs[7];

  program_out_streamer dut (
    .clock       (clock),
    .reset       (reset),
    .program_out (program_out),
    .capture_en  (capture_en),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_first   (out_first),
    .overflow    (overflow),
    .fifo_level  (fifo_level)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic push_word(input logic [31:0] w);
    for (int b = 0; b < 4; b++) begin
      beat_t bt;
      bt.data  = w[31-8*b -: 8];
      bt.first = (b == 0);
      exp_q.push_back(bt);
    end
  endtask

  task automatic drain(input string name, input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || out_valid) && n < budget) begin
      tick();
      n++;
    end
    check({name, "_drain_left"}, exp_q.size(), 0);
    check({name, "_idle"}, {31'd0, out_valid}, 32'd0);
  endtask

  // Byte monitor: pops the scoreboard on each handshake and checks that a
  // stalled byte stays put until it is taken.
  logic       prev_v = 1'b0;
  logic       prev_r = 1'b0;
  logic [7:0] prev_d = 8'h00;

  always @(negedge clock) begin
    if (reset) begin
      prev_v = 1'b0;
    end else begin
      if (prev_v && !prev_r) begin
        check("stall_valid", {31'd0, out_valid}, 32'd1);
        check("stall_data", {24'd0, out_data}, {24'd0, prev_d});
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_byte", {24'd0, out_data}, 32'hFFFF_FFFF);
        end else begin
          beat_t e;
          e = exp_q.pop_front();
          check("byte_data", {24'd0, out_data}, {24'd0, e.data});
          check("byte_first", {31'd0, out_first}, {31'd0, e.first});
        end
      end
      prev_v = out_valid;
      prev_r = out_ready;
      prev_d = out_data;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic ready_pat [4];

    vecs[0] = '{cap: 1'b1, val: 32'h1234_5678, exp_push: 1'b0};
    vecs[1] = '{cap: 1'b1, val: 32'hCAFE_BABE, exp_push: 1'b1};
    vecs[2] = '{cap: 1'b0, val: 32'h1111_1111, exp_push: 1'b0};
    vecs[3] = '{cap: 1'b1, val: 32'hCAFE_BABE, exp_push: 1'b0};
    vecs[4] = '{cap: 1'b1, val: 32'h1111_1111, exp_push: 1'b1};
    vecs[5] = '{cap: 1'b1, val: 32'h0000_0000, exp_push: 1'b1};
    vecs[6] = '{cap: 1'b0, val: 32'h0000_0000, exp_push: 1'b0};

    // Test 1: reset, then the first capture of 0 is always sent.
    reset       = 1'b1;
    capture_en  = 1'b1;
    program_out = 32'h0;
    out_ready   = 1'b1;
    repeat (5) tick();
    check("rst_valid", {31'd0, out_valid}, 32'd0);
    check("rst_first", {31'd0, out_first}, 32'd0);
    check("rst_data", {24'd0, out_data}, 32'd0);
    check("rst_overflow", {31'd0, overflow}, 32'd0);
    check("rst_level", {29'd0, fifo_level}, 32'd0);
    push_word(32'h0);
    reset = 1'b0;
    tick();
    check("t1_level_after_push", {29'd0, fifo_level}, 32'd1);
    drain("t1", 20);
    repeat (8) tick();
    check("t1_no_repeat_level", {29'd0, fifo_level}, 32'd0);
    check("t1_no_repeat_valid", {31'd0, out_valid}, 32'd0);

    // Test 2: steady word, exact latency N+2..N+5, idle at N+6.
    program_out = 32'h1234_5678;
    push_word(32'h1234_5678);
    tick();
    tick();
    check("t2_n2_valid", {31'd0, out_valid}, 32'd1);
    check("t2_n2_data", {24'd0, out_data}, 32'h12);
    check("t2_n2_first", {31'd0, out_first}, 32'd1);
    tick();
    check("t2_n3_data", {24'd0, out_data}, 32'h34);
    check("t2_n3_first", {31'd0, out_first}, 32'd0);
    tick();
    check("t2_n4_data", {24'd0, out_data}, 32'h56);
    tick();
    check("t2_n5_data", {24'd0, out_data}, 32'h78);
    tick();
    check("t2_n6_valid", {31'd0, out_valid}, 32'd0);
    repeat (10) tick();
    check("t2_hold_level", {29'd0, fifo_level}, 32'd0);
    check("t2_hold_sb", exp_q.size(), 0);

    // Vector table: change detection and capture_en gating.
    for (int i = 0; i < 7; i++) begin
      capture_en  = vecs[i].cap;
      program_out = vecs[i].val;
      if (vecs[i].exp_push) push_word(vecs[i].val);
      tick();
      check($sformatf("vec%0d_level", i), {29'd0, fifo_level}, {31'd0, vecs[i].exp_push});
      repeat (7) tick();
      check($sformatf("vec%0d_sb", i), exp_q.size(), 0);
    end

    // Test 3: stalled sink, six new words, sixth dropped.
    capture_en = 1'b1;
    out_ready  = 1'b0;
    for (int v = 1; v <= 6; v++) begin
      program_out = v;
      if (v <= 5) push_word(v);
      tick();
    end
    check("t3_level_full", {29'd0, fifo_level}, 32'd4);
    check("t3_overflow", {31'd0, overflow}, 32'd1);
    check("t3_valid_stalled", {31'd0, out_valid}, 32'd1);
    check("t3_head_byte", {24'd0, out_data}, 32'h00);
    out_ready = 1'b1;
    drain("t3", 60);
    check("t3_overflow_sticky", {31'd0, overflow}, 32'd1);

    // Test 4: backpressure pattern 1,0,0,1.
    ready_pat[0] = 1'b1;
    ready_pat[1] = 1'b0;
    ready_pat[2] = 1'b0;
    ready_pat[3] = 1'b1;
    program_out = 32'hA5C3_F00F;
    push_word(32'hA5C3_F00F);
    for (int c = 0; c < 20; c++) begin
      out_ready = ready_pat[c % 4];
      tick();
    end
    out_ready = 1'b1;
    drain("t4", 20);

    // Test 5: reset while the second byte of DEADBEEF is on the bus.
    program_out = 32'hDEAD_BEEF;
    begin
      beat_t bt;
      bt.data  = 8'hDE;
      bt.first = 1'b1;
      exp_q.push_back(bt);
    end
    tick();
    tick();
    check("t5_beat0", {24'd0, out_data}, 32'hDE);
    tick();
    check("t5_beat1", {24'd0, out_data}, 32'hAD);
    reset = 1'b1;
    tick();
    check("t5_rst_valid", {31'd0, out_valid}, 32'd0);
    check("t5_rst_level", {29'd0, fifo_level}, 32'd0);
    check("t5_rst_overflow", {31'd0, overflow}, 32'd0);
    check("t5_rst_sb", exp_q.size(), 0);
    reset = 1'b0;
    push_word(32'hDEAD_BEEF);
    drain("t5", 20);
    repeat (6) tick();
    check("t5_no_dup", exp_q.size(), 0);

    // Test 6: capture disabled, then enabled once.
    capture_en  = 1'b0;
    program_out = 32'h0000_0077;
    repeat (8) tick();
    check("t6_gated_valid", {31'd0, out_valid}, 32'd0);
    check("t6_gated_level", {29'd0, fifo_level}, 32'd0);
    capture_en = 1'b1;
    push_word(32'h0000_0077);
    drain("t6", 20);
    repeat (8) tick();
    check("t6_single", {29'd0, fifo_level}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
